// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of player bullets advanced once per video frame.
// A fire key press claims the lowest free slot at the player's X position;
// each active bullet climbs Y_STEP pixels per frame until it reaches the
// ceiling or a collision strobe frees it. A cooldown counter spaces shots.
// Optional build macro: BULLET_POOL_AUTOFIRE_EN -- when defined, a held
// fire key keeps firing (level request) instead of firing once per press.
module bullet_pool #(
   parameter int          NUM_BULLETS = 4,
   parameter int          Y_START     = 136,
   parameter int          Y_MIN       = 0,
   parameter int          Y_STEP      = 1,
   parameter int          COOLDOWN    = 8,
   parameter logic [7:0]  FIRE_KEY    = 8'h44
) (
   input  logic                        frame_clk,
   input  logic                        Reset_n,
   input  logic [7:0]                  keycode,
   input  logic [9:0]                  player_X,
   input  logic                        ready_game,
   input  logic [NUM_BULLETS-1:0]      hit,
   output logic [10*NUM_BULLETS-1:0]   bullet_X,
   output logic [10*NUM_BULLETS-1:0]   bullet_Y,
   output logic [NUM_BULLETS-1:0]      bullet_active,
   output logic                        fired,
   output logic                        pool_full
);

   localparam int              CW        = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
   localparam logic [CW-1:0]   COOL_LOAD = CW'(COOLDOWN);
   localparam logic [9:0]      Y_START_V = 10'(Y_START);
   localparam logic [9:0]      Y_STEP_V  = 10'(Y_STEP);
   // A bullet at or below this height would reach or pass the ceiling on
   // its next step, so it is retired instead of moved (also prevents wrap).
   localparam logic [10:0]     Y_LIMIT   = 11'(Y_MIN + Y_STEP);

   logic                        r_key_prev;
   logic [CW-1:0]               r_cool;
   logic [NUM_BULLETS-1:0]      r_active;
   logic [10*NUM_BULLETS-1:0]   r_x;
   logic [10*NUM_BULLETS-1:0]   r_y;
   logic                        r_fired;

   logic                        w_key_match;
   logic                        w_fire_req;
   logic [NUM_BULLETS-1:0]      w_grant;
   logic                        w_found;
   logic                        w_accept;

   assign w_key_match = (keycode == FIRE_KEY);

`ifdef BULLET_POOL_AUTOFIRE_EN
   assign w_fire_req = w_key_match;
`else
   assign w_fire_req = w_key_match & ~r_key_prev;
`endif

   // One-hot grant of the lowest-index slot that is free at the start of the frame.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (!r_active[i] && !w_found) begin
            w_grant[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

   assign w_accept = ready_game & w_fire_req & (r_cool == '0) & w_found;

   // Per-frame state update: edge register, cooldown, slot allocation and motion.
   always_ff @(posedge frame_clk) begin
      if (!Reset_n) begin
         r_key_prev <= 1'b0;
         r_cool     <= '0;
         r_active   <= '0;
         r_fired    <= 1'b0;
         r_x        <= '0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            r_y[10*i +: 10] <= Y_START_V;
         end
      end else begin
         // Tracks the key even while paused so a held key cannot fire on resume.
         r_key_prev <= w_key_match;
         if (ready_game) begin
            r_fired <= w_accept;
            if (w_accept) begin
               r_cool <= COOL_LOAD;
            end else if (r_cool != '0) begin
               r_cool <= r_cool - 1'b1;
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
               if (w_accept && w_grant[i]) begin
                  r_active[i]     <= 1'b1;
                  r_y[10*i +: 10] <= Y_START_V;
                  r_x[10*i +: 10] <= player_X;
               end else if (r_active[i]) begin
                  if (hit[i] || ({1'b0, r_y[10*i +: 10]} <= Y_LIMIT)) begin
                     r_active[i]     <= 1'b0;
                     r_y[10*i +: 10] <= Y_START_V;
                  end else begin
                     r_y[10*i +: 10] <= r_y[10*i +: 10] - Y_STEP_V;
                  end
               end
            end
         end else begin
            r_fired <= 1'b0;
         end
      end
   end

   assign bullet_X      = r_x;
   assign bullet_Y      = r_y;
   assign bullet_active = r_active;
   assign fired         = r_fired;
   assign pool_full     = &r_active;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: frame-by-frame scoreboard bench for bullet_pool
// (NUM_BULLETS=3, COOLDOWN=4, other parameters at default, edge-fire build).
module tb_bullet_pool;

   localparam int         NB = 3;
   localparam int         W  = NB + 2 + 20 * NB;
   localparam logic [7:0] K  = 8'h44;
   localparam logic [7:0] N  = 8'h00;

   logic               frame_clk = 1'b0;
   logic               Reset_n;
   logic [7:0]         keycode;
   logic [9:0]         player_X;
   logic               ready_game;
   logic [NB-1:0]      hit;
   logic [10*NB-1:0]   bullet_X;
   logic [10*NB-1:0]   bullet_Y;
   logic [NB-1:0]      bullet_active;
   logic               fired;
   logic               pool_full;

   // clock / reset block: one period per frame; reset is driven per frame below
   always #5 frame_clk = ~frame_clk;

   bullet_pool #(
      .NUM_BULLETS (NB),
      .COOLDOWN    (4)
   ) dut (
      .frame_clk     (frame_clk),
      .Reset_n       (Reset_n),
      .keycode       (keycode),
      .player_X      (player_X),
      .ready_game    (ready_game),
      .hit           (hit),
      .bullet_X      (bullet_X),
      .bullet_Y      (bullet_Y),
      .bullet_active (bullet_active),
      .fired         (fired),
      .pool_full     (pool_full)
   );

   // reference model state
   bit  m_act [NB];
   int  m_x   [NB];
   int  m_y   [NB];
   int  m_cool;
   bit  m_prev;
   bit  m_fired;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Model of one frame edge using the inputs currently applied.
   task automatic model_step();
      bit key, req, take;
      int slot;
      key = (keycode == K);
      if (!Reset_n) begin
         for (int i = 0; i < NB; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 136;
         end
         m_cool  = 0;
         m_prev  = 1'b0;
         m_fired = 1'b0;
         return;
      end
      req    = key && !m_prev;
      m_prev = key;
      if (!ready_game) begin
         m_fired = 1'b0;
         return;
      end
      slot = -1;
      for (int i = 0; i < NB; i++) if (!m_act[i] && slot < 0) slot = i;
      take = req && (m_cool == 0) && (slot >= 0);
      for (int i = 0; i < NB; i++) begin
         if (m_act[i]) begin
            if (hit[i] || m_y[i] <= 1) begin
               m_act[i] = 1'b0;
               m_y[i]   = 136;
            end else begin
               m_y[i] = m_y[i] - 1;
            end
         end
      end
      if (take) begin
         m_act[slot] = 1'b1;
         m_x[slot]   = int'(player_X);
         m_y[slot]   = 136;
         m_cool      = 4;
      end else if (m_cool > 0) begin
         m_cool = m_cool - 1;
      end
      m_fired = take;
   endtask

   function automatic logic [W-1:0] model_pack();
      logic [NB-1:0]    a;
      logic [10*NB-1:0] xv, yv;
      for (int i = 0; i < NB; i++) begin
         a[i]           = m_act[i];
         xv[10*i +: 10] = 10'(m_x[i]);
         yv[10*i +: 10] = 10'(m_y[i]);
      end
      return {a, m_fired, &a, xv, yv};
   endfunction

   // driver: apply one frame of inputs, predict, then compare after the edge
   task automatic frame(input logic [7:0] kc, input logic [9:0] px, input logic rdy,
                        input logic [NB-1:0] h, input logic rn);
      @(negedge frame_clk);
      keycode    = kc;
      player_X   = px;
      ready_game = rdy;
      hit        = h;
      Reset_n    = rn;
      model_step();
      exp_q.push_back(model_pack());
      @(posedge frame_clk);
      #1;
      if (exp_q.size() == 0) begin
         check_val("queue_empty", W'(1), W'(0));
      end else begin
         check_val("frame", {bullet_active, fired, pool_full, bullet_X, bullet_Y}, exp_q.pop_front());
      end
   endtask

   initial begin
      keycode = N; player_X = '0; ready_game = 1'b1; hit = '0; Reset_n = 1'b0;

      // reset state
      repeat (2) frame(N, 0, 1, 0, 0);
      check_val("rst_active", W'(bullet_active), W'(0));
      check_val("rst_y", W'(bullet_Y), W'({3{10'd136}}));
      check_val("rst_fired", W'(fired), W'(0));

      // first shot and first step
      frame(K, 200, 1, 0, 1);
      check_val("shot_active", W'(bullet_active), W'(3'b001));
      check_val("shot_x", W'(bullet_X[9:0]), W'(10'd200));
      check_val("shot_y", W'(bullet_Y[9:0]), W'(10'd136));
      check_val("shot_fired", W'(fired), W'(1));
      frame(N, 0, 1, 0, 1);
      check_val("step_y", W'(bullet_Y[9:0]), W'(10'd135));
      check_val("step_fired", W'(fired), W'(0));

      // press two frames after an accepted shot: cooldown drop
      frame(K, 250, 1, 0, 1);
      check_val("cool_drop", W'({bullet_active, fired}), W'({3'b001, 1'b0}));
      frame(N, 0, 1, 0, 1);
      frame(N, 0, 1, 0, 1);
      frame(K, 300, 1, 0, 1);
      check_val("shot2", W'({bullet_active, fired, bullet_X[19:10]}), W'({3'b011, 1'b1, 10'd300}));
      repeat (4) frame(N, 0, 1, 0, 1);
      frame(K, 400, 1, 0, 1);
      check_val("shot3_full", W'({bullet_active, pool_full, bullet_X[29:20]}), W'({3'b111, 1'b1, 10'd400}));
      repeat (4) frame(N, 0, 1, 0, 1);
      frame(K, 450, 1, 0, 1);
      check_val("full_drop", W'({fired, pool_full}), W'({1'b0, 1'b1}));

      // hit on slot1 with a simultaneous press: freed, not reallocated
      repeat (4) frame(N, 0, 1, 0, 1);
      frame(K, 500, 1, 3'b010, 1);
      check_val("hit_no_alloc", W'({bullet_active, fired}), W'({3'b101, 1'b0}));
      frame(N, 0, 1, 0, 1);
      frame(K, 123, 1, 0, 1);
      check_val("realloc_slot1", W'({bullet_active, fired, bullet_X[19:10]}), W'({3'b111, 1'b1, 10'd123}));

      // pause with key rising and held across it: no shot on resume
      frame(N, 0, 1, 3'b001, 1);
      repeat (10) frame(K, 77, 0, 0, 1);
      check_val("pause_fired", W'(fired), W'(0));
      repeat (6) frame(K, 77, 1, 0, 1);
      check_val("resume_nofire", W'({bullet_active, fired}), W'({3'b110, 1'b0}));

      // let everything reach the ceiling
      repeat (140) frame(N, 0, 1, 0, 1);
      check_val("ceiling", W'({bullet_active, bullet_Y}), W'({3'b000, {3{10'd136}}}));

      // random traffic
      repeat (400) begin
         logic [7:0]    kc;
         logic [NB-1:0] h;
         kc = ($urandom_range(0, 2) == 0) ? K : N;
         h  = ($urandom_range(0, 7) == 0) ? NB'($urandom_range(0, 7)) : '0;
         frame(kc, 10'($urandom_range(0, 639)), ($urandom_range(0, 9) != 0), h,
               ($urandom_range(0, 99) != 0));
      end

      // reset mid-flight with two bullets, then an immediate fresh press
      frame(N, 0, 1, 0, 0);
      frame(K, 10, 1, 0, 1);
      repeat (4) frame(N, 0, 1, 0, 1);
      frame(K, 20, 1, 0, 1);
      frame(N, 0, 1, 0, 1);
      check_val("two_active", W'(bullet_active), W'(3'b011));
      frame(N, 0, 1, 0, 0);
      check_val("midrst", W'({bullet_active, fired, bullet_Y}), W'({3'b000, 1'b0, {3{10'd136}}}));
      frame(K, 33, 1, 0, 1);
      check_val("post_rst_shot", W'({bullet_active, fired, bullet_X[9:0]}), W'({3'b001, 1'b1, 10'd33}));

      check_val("queue_drained", W'(exp_q.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter NUM_BULLETS, default 4, number of bullet slots (1..16).
REQ-002 Parameter Y_START, default 136, launch Y position; Y_MIN, default 0, ceiling; Y_STEP, default 1, pixels moved upward per frame.
REQ-003 Parameter COOLDOWN, default 8, frames between accepted shots; FIRE_KEY, default 8'h44, fire keycode.
REQ-004 frame_clk  input  1  sole clock, one rising edge per video frame.
REQ-005 Reset_n  input  1  synchronous active-low reset, sampled on frame_clk.
REQ-006 keycode  input  8  current keyboard code; player_X  input  10  player X position.
REQ-007 ready_game  input  1  game running; low freezes the block.
REQ-008 hit  input  NUM_BULLETS  per-slot collision strobe.
REQ-009 bullet_X, bullet_Y  output  10*NUM_BULLETS each  packed per-slot positions, slot i at bits [10i+9:10i].
REQ-010 bullet_active  output  NUM_BULLETS  per-slot on-screen flag; fired  output  1  one-frame pulse on accepted shot; pool_full  output  1  all slots active.

Function
REQ-011 fire_req SHALL be the rising edge of (keycode == FIRE_KEY), using a registered previous-frame compare.
REQ-012 A shot SHALL be accepted when ready_game=1, fire_req=1, cooldown counter=0 and at least one slot is inactive at the start of the cycle.
REQ-013 An accepted shot SHALL allocate the lowest-index inactive slot: active<=1, Y<=Y_START, X<=player_X sampled that edge; X then holds until the slot frees.
REQ-014 An accepted shot SHALL pulse fired for exactly one frame and load the cooldown counter with COOLDOWN.
REQ-015 The cooldown counter SHALL decrement by 1 per frame while nonzero and ready_game=1, saturating at 0.
REQ-016 Each active slot not allocated this cycle SHALL move Y<=Y-Y_STEP per frame.
REQ-017 A slot SHALL deactivate when Y <= Y_MIN+Y_STEP (next step would reach or pass ceiling), with Y<=Y_START; Y never wraps below 0.
REQ-018 hit[i]=1 on an active slot SHALL deactivate it that edge with Y<=Y_START; hit[i] on an inactive slot SHALL be ignored.
REQ-019 A slot freed by hit or ceiling SHALL NOT be reallocated in the same cycle; free-slot search uses start-of-cycle state.
REQ-020 Fire request with pool full or cooldown nonzero SHALL be dropped, not queued.
REQ-021 ready_game=0 SHALL hold all slots, cooldown and outputs (fired=0); the edge register keeps updating so a key held through a pause does not fire on resume.
REQ-022 pool_full SHALL be the AND of bullet_active, combinational from registered state.
REQ-023 All outputs SHALL be driven from registers, latency one frame from input to output.

Reset
REQ-024 Reset_n=0 SHALL clear bullet_active, fired, cooldown counter and edge register, set all Y to Y_START and all X to 0, regardless of ready_game.
REQ-025 Reset mid-flight SHALL remove all bullets at that edge; first shot is possible on the first frame after reset release with a fresh key press.

Configuration
REQ-026 Macro BULLET_POOL_AUTOFIRE_EN defined: fire_req SHALL be the level (keycode == FIRE_KEY), so a held key fires whenever cooldown reaches 0 and a slot is free.
REQ-027 Macro BULLET_POOL_AUTOFIRE_EN undefined: fire_req SHALL be edge-triggered per REQ-011; the held key fires once.

Verification
REQ-028 NUM_BULLETS=3, COOLDOWN=4, player_X=200, press 8'h44 one frame -> slot0 active, X=200, Y=136, fired=1 one frame; Y=135 next frame.
REQ-029 Slot0 in flight, Y_STEP=1, Y_MIN=0 -> slot0 deactivates at the edge where Y=1, Y returns to 136, no Y underflow.
REQ-030 Three presses spaced 5 frames, fourth press 5 frames later -> slots 0,1,2 active, pool_full=1, fourth dropped with fired=0; a press 2 frames after an accepted shot is dropped (cooldown).
REQ-031 hit=3'b010 while slots 0-2 active and key pressed same frame -> slot1 cleared, no allocation that frame; next accepted press allocates slot1.
REQ-032 ready_game=0 for 10 frames with key held across -> positions frozen, no shot on resume (edge mode); with BULLET_POOL_AUTOFIRE_EN, held key fires every 5 frames until pool_full.
REQ-033 Reset_n=0 for one frame with 2 bullets active -> bullet_active=0, cooldown=0, all Y=136 next frame.
